rgb_pwm_engine: RTL and testbench

RGB_PWM_ENGINE -- requirements
Module: rgb_pwm_engine

---
 rtl/rgb_pwm_engine.sv | 156 +++++++++++++++
 tb/tb_rgb_pwm_engine.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_pwm_engine.sv
// RGB PWM engine: per-LED static colour or colour-wheel source, shadowed once per PWM period.
// Define RGB_PWM_GAMMA_EN to square-law shape each duty before it reaches the shadow registers.
module rgb_pwm_engine #(
    parameter int unsigned NUM_LEDS   = 2,
    parameter int unsigned PWM_BITS   = 8,
    parameter int unsigned STEP_DIV   = 1000000,
    parameter int unsigned HUE_OFFSET = 0
) (
    input  logic                                             GCLK,
    input  logic                                             RST,
    input  logic [NUM_LEDS-1:0]                              mode,
    input  logic                                             wr_valid,
    output logic                                             wr_ready,
    input  logic [((NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1)-1:0] wr_led,
    input  logic [3*PWM_BITS-1:0]                            wr_rgb,
    output logic                                             wr_err,
    output logic [3*NUM_LEDS-1:0]                            RGB_LED_O
);

    localparam int unsigned M       = 1 << PWM_BITS;
    localparam int unsigned HueMax  = 3 * M;
    localparam int unsigned HueW    = $clog2(HueMax);
    localparam int unsigned HueSumW = HueW + 1;
    localparam int unsigned StepW   = $clog2(STEP_DIV);
    localparam int unsigned NumCh   = 3 * NUM_LEDS;

    localparam logic [PWM_BITS-1:0] PwmLast  = PWM_BITS'(M - 2);
    localparam logic [StepW-1:0]    StepLast = StepW'(STEP_DIV - 1);
    localparam logic [HueW-1:0]     HueLast  = HueW'(HueMax - 1);

    logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic [StepW-1:0]      step_cnt_q, step_cnt_d;
    logic [HueW-1:0]       hue_q, hue_d;
    logic [3*PWM_BITS-1:0] static_q [NUM_LEDS];
    logic [3*PWM_BITS-1:0] static_d [NUM_LEDS];
    logic [PWM_BITS-1:0]   shadow_q [NumCh];
    logic [PWM_BITS-1:0]   shadow_d [NumCh];
    logic                  wr_err_q, wr_err_d;
    logic [NumCh-1:0]      led_q, led_d;
    logic [3*PWM_BITS-1:0] wheel_rgb [NUM_LEDS];

    function automatic logic [PWM_BITS-1:0] shape(input logic [PWM_BITS-1:0] v);
`ifdef RGB_PWM_GAMMA_EN
        logic [2*PWM_BITS-1:0] sq;
        sq = {{PWM_BITS{1'b0}}, v} * {{PWM_BITS{1'b0}}, v};
        return sq[2*PWM_BITS-1:PWM_BITS];
`else
        return v;
`endif
    endfunction

    assign wr_ready  = ~RST;
    assign wr_err    = wr_err_q;
    assign RGB_LED_O = led_q;

    always_comb begin
        pwm_cnt_d  = (pwm_cnt_q == PwmLast) ? '0 : pwm_cnt_q + 1'b1;
        step_cnt_d = (step_cnt_q == StepLast) ? '0 : step_cnt_q + 1'b1;
        hue_d      = hue_q;
        if (step_cnt_q == StepLast) begin
            hue_d = (hue_q == HueLast) ? '0 : hue_q + 1'b1;
        end
    end

    // Hue wheel: three linear segments, each a cross-fade between two primaries.
    always_comb begin
        logic [HueSumW-1:0]  h;
        logic [PWM_BITS-1:0] f;
        logic [PWM_BITS-1:0] fi;
        h  = '0;
        f  = '0;
        fi = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            h = {1'b0, hue_q} + HueSumW'((i * HUE_OFFSET) % HueMax);
            if (h >= HueSumW'(HueMax)) begin
                h = h - HueSumW'(HueMax);
            end
            f  = h[PWM_BITS-1:0];
            fi = ~f;
            if (h < HueSumW'(M)) begin
                wheel_rgb[i] = {f, fi, {PWM_BITS{1'b0}}};
            end else if (h < HueSumW'(2 * M)) begin
                wheel_rgb[i] = {fi, {PWM_BITS{1'b0}}, f};
            end else begin
                wheel_rgb[i] = {{PWM_BITS{1'b0}}, f, fi};
            end
        end
    end

    always_comb begin
        logic [3*PWM_BITS-1:0] sel;
        sel      = '0;
        wr_err_d = wr_err_q;
        for (int i = 0; i < NUM_LEDS; i++) begin
            static_d[i] = static_q[i];
        end
        for (int c = 0; c < NumCh; c++) begin
            shadow_d[c] = shadow_q[c];
        end

        if (wr_valid && wr_ready) begin
            if (int'(wr_led) >= NUM_LEDS) begin
                wr_err_d = 1'b1;
            end else begin
                for (int i = 0; i < NUM_LEDS; i++) begin
                    if (int'(wr_led) == i) begin
                        static_d[i] = wr_rgb;
                    end
                end
            end
        end

        // Loads from static_q, so a write landing on this same edge waits one period.
        if (pwm_cnt_q == PwmLast) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                sel = mode[i] ? wheel_rgb[i] : static_q[i];
                for (int c = 0; c < 3; c++) begin
                    shadow_d[3*i+c] = shape(sel[c*PWM_BITS +: PWM_BITS]);
                end
            end
        end

        for (int c = 0; c < NumCh; c++) begin
            led_d[c] = shadow_q[c] > pwm_cnt_q;
        end
    end

    always_ff @(posedge GCLK or posedge RST) begin
        if (RST) begin
            pwm_cnt_q  <= '0;
            step_cnt_q <= '0;
            hue_q      <= '0;
            wr_err_q   <= 1'b0;
            led_q      <= '0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                static_q[i] <= '0;
            end
            for (int c = 0; c < NumCh; c++) begin
                shadow_q[c] <= '0;
            end
        end else begin
            pwm_cnt_q  <= pwm_cnt_d;
            step_cnt_q <= step_cnt_d;
            hue_q      <= hue_d;
            wr_err_q   <= wr_err_d;
            led_q      <= led_d;
            for (int i = 0; i < NUM_LEDS; i++) begin
                static_q[i] <= static_d[i];
            end
            for (int c = 0; c < NumCh; c++) begin
                shadow_q[c] <= shadow_d[c];
            end
        end
    end

endmodule

// File: tb/tb_rgb_pwm_engine.sv
// Directed bench for rgb_pwm_engine (M=16, STEP_DIV=4, HUE_OFFSET=16); duty measured by
// counting high samples across one full 15-cycle PWM period.
module tb_rgb_pwm_engine;

    logic GCLK = 1'b0;
    logic RST  = 1'b1;
    always #5 GCLK = ~GCLK;

    logic [1:0]  mode     = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [0:0]  wr_led   = '0;
    logic [11:0] wr_rgb   = '0;
    logic        wr_err;
    logic [5:0]  led;

    logic [2:0]  mode3     = '0;
    logic        wr_valid3 = 1'b0;
    logic        wr_ready3;
    logic [1:0]  wr_led3   = '0;
    logic [11:0] wr_rgb3   = '0;
    logic        wr_err3;
    logic [8:0]  led3;

    rgb_pwm_engine #(.NUM_LEDS(2), .PWM_BITS(4), .STEP_DIV(4), .HUE_OFFSET(16)) dut (
        .GCLK(GCLK), .RST(RST), .mode(mode), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_led(wr_led), .wr_rgb(wr_rgb), .wr_err(wr_err), .RGB_LED_O(led)
    );

    rgb_pwm_engine #(.NUM_LEDS(3), .PWM_BITS(4), .STEP_DIV(4), .HUE_OFFSET(16)) dut3 (
        .GCLK(GCLK), .RST(RST), .mode(mode3), .wr_valid(wr_valid3), .wr_ready(wr_ready3),
        .wr_led(wr_led3), .wr_rgb(wr_rgb3), .wr_err(wr_err3), .RGB_LED_O(led3)
    );

    // Edges since reset release; pwm_cnt after edge k is k mod 15.
    int cyc;
    always @(posedge GCLK or posedge RST) begin
        if (RST) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    int n_pass = 0;
    int n_chk  = 0;
    int cnt_a [6];
    int cnt_b [9];
    int load_cyc;
    int st [2][3];

    typedef struct {
        int led;
        int r, g, b;
        int er, eg, eb;
    } vec_t;
    vec_t tbl [5];

    function automatic int gam(input int v);
`ifdef RGB_PWM_GAMMA_EN
        return (v * v) >> 4;
`else
        return v;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic align(input int ph);
        int guard = 0;
        while (cyc % 15 != ph) begin
            @(negedge GCLK);
            guard++;
            if (guard > 40) begin
                check("align_timeout", 0, 1);
                break;
            end
        end
    endtask

    // Waits for a period boundary, then counts high samples over that whole period.
    task automatic measure(input int sw_at, input logic [1:0] sw_mode);
        align(0);
        load_cyc = cyc;
        for (int b = 0; b < 6; b++) cnt_a[b] = 0;
        for (int b = 0; b < 9; b++) cnt_b[b] = 0;
        for (int j = 0; j < 15; j++) begin
            @(negedge GCLK);
            if (j == sw_at) mode = sw_mode;
            for (int b = 0; b < 6; b++) cnt_a[b] += int'(led[b]);
            for (int b = 0; b < 9; b++) cnt_b[b] += int'(led3[b]);
        end
    endtask

    task automatic expect_led(input string nm, input int i, input int r, input int g,
                              input int b);
        check({nm, "_r"}, cnt_a[3*i+2], gam(r));
        check({nm, "_g"}, cnt_a[3*i+1], gam(g));
        check({nm, "_b"}, cnt_a[3*i],   gam(b));
    endtask

    task automatic expect_led3(input string nm, input int i, input int r, input int g,
                               input int b);
        check({nm, "_r"}, cnt_b[3*i+2], gam(r));
        check({nm, "_g"}, cnt_b[3*i+1], gam(g));
        check({nm, "_b"}, cnt_b[3*i],   gam(b));
    endtask

    task automatic expect_wheel(input string nm, input int i, input int h);
        int f;
        f = h % 16;
        case (h / 16)
            0:       expect_led(nm, i, f, 15 - f, 0);
            1:       expect_led(nm, i, 15 - f, 0, f);
            default: expect_led(nm, i, 0, f, 15 - f);
        endcase
    endtask

    task automatic write_led(input int l, input int r, input int g, input int b);
        wr_valid = 1'b1;
        wr_led   = 1'(l);
        wr_rgb   = {4'(r), 4'(g), 4'(b)};
        @(negedge GCLK);
        wr_valid = 1'b0;
    endtask

    task automatic expect_static(input string nm);
        expect_led({nm, "_l0"}, 0, st[0][0], st[0][1], st[0][2]);
        expect_led({nm, "_l1"}, 1, st[1][0], st[1][1], st[1][2]);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, expected finish before 100000ns");
        $fatal(1, "timeout");
    end

    initial begin
        int h0;
        int nz;
        tbl[0] = '{led: 0, r: 15, g: 8,  b: 0,  er: 15, eg: 8,  eb: 0};
        tbl[1] = '{led: 1, r: 1,  g: 14, b: 7,  er: 1,  eg: 14, eb: 7};
        tbl[2] = '{led: 0, r: 0,  g: 15, b: 3,  er: 0,  eg: 15, eb: 3};
        tbl[3] = '{led: 1, r: 9,  g: 2,  b: 12, er: 9,  eg: 2,  eb: 12};
        tbl[4] = '{led: 0, r: 15, g: 6,  b: 1,  er: 15, eg: 6,  eb: 1};
        for (int i = 0; i < 2; i++) for (int c = 0; c < 3; c++) st[i][c] = 0;

        // Reset state
        #1;
        check("rst_led", int'(led), 0);
        check("rst_ready", int'(wr_ready), 0);
        check("rst_err", int'(wr_err), 0);
        check("rst_err3", int'(wr_err3), 0);
        @(negedge GCLK);
        RST = 1'b0;
        #1;
        check("ready_after_rst", int'(wr_ready), 1);
        @(negedge GCLK);

        // Static writes, table-driven
        for (int k = 0; k < 5; k++) begin
            align(3);
            write_led(tbl[k].led, tbl[k].r, tbl[k].g, tbl[k].b);
            st[tbl[k].led][0] = tbl[k].r;
            st[tbl[k].led][1] = tbl[k].g;
            st[tbl[k].led][2] = tbl[k].b;
            measure(-1, mode);
            expect_led($sformatf("tbl%0d_wr", k), tbl[k].led, tbl[k].er, tbl[k].eg, tbl[k].eb);
            expect_led($sformatf("tbl%0d_other", k), 1 - tbl[k].led,
                       st[1-tbl[k].led][0], st[1-tbl[k].led][1], st[1-tbl[k].led][2]);
        end

`ifdef RGB_PWM_GAMMA_EN
        align(3);
        write_led(1, 8, 15, 0);
        measure(-1, mode);
        check("gamma_r8", cnt_a[5], 4);
        check("gamma_g15", cnt_a[4], 14);
        check("gamma_b0", cnt_a[3], 0);
        st[1][0] = 8; st[1][1] = 15; st[1][2] = 0;
`endif

        // Back-to-back writes to one LED within a period: last one wins
        align(3);
        write_led(1, 2, 2, 2);
        write_led(1, 11, 5, 13);
        st[1][0] = 11; st[1][1] = 5; st[1][2] = 13;
        measure(-1, mode);
        expect_static("consec");

        // Write accepted on the shadow-load edge is held off one period
        align(14);
        write_led(1, 4, 4, 4);
        measure(-1, mode);
        expect_static("collide_old");
        st[1][0] = 4; st[1][1] = 4; st[1][2] = 4;
        measure(-1, mode);
        expect_static("collide_new");

        // Out-of-range write on the 3-LED instance
        wr_valid3 = 1'b1;
        wr_led3   = 2'd3;
        wr_rgb3   = 12'hFFF;
        @(negedge GCLK);
        wr_valid3 = 1'b0;
        check("err_set", int'(wr_err3), 1);
        check("err_other_dut", int'(wr_err), 0);
        measure(-1, mode);
        nz = 0;
        for (int b = 0; b < 9; b++) nz += cnt_b[b];
        check("err_no_write", nz, 0);
        align(3);
        wr_valid3 = 1'b1;
        wr_led3   = 2'd2;
        wr_rgb3   = {4'd5, 4'd0, 4'd10};
        @(negedge GCLK);
        wr_valid3 = 1'b0;
        measure(-1, mode);
        expect_led3("err_l2", 2, 5, 0, 10);
        expect_led3("err_l0", 0, 0, 0, 0);
        check("err_sticky", int'(wr_err3), 1);

        // Mode change mid-period is deferred to the boundary, then the wheel runs through wrap
        measure(7, 2'b11);
        expect_static("mode_defer");
        for (int p = 0; p < 14; p++) begin
            measure(-1, mode);
            h0 = ((load_cyc - 1) / 4) % 48;
            expect_wheel($sformatf("wheel%0d_l0", p), 0, h0);
            expect_wheel($sformatf("wheel%0d_l1", p), 1, (h0 + 16) % 48);
        end
        measure(7, 2'b00);
        h0 = ((load_cyc - 1) / 4) % 48;
        expect_wheel("wheel_defer_l0", 0, h0);
        measure(-1, mode);
        expect_static("back_static");

        // Reset mid-run: pending write discarded, outputs cleared without a clock edge
        write_led(1, 7, 7, 7);
        check("pre_rst_r", int'(led[2]), 1);
        mode = 2'b01;
        #2;
        RST = 1'b1;
        #1;
        check("midrst_led", int'(led), 0);
        check("midrst_led3", int'(led3), 0);
        check("midrst_ready", int'(wr_ready), 0);
        check("midrst_err3", int'(wr_err3), 0);
        for (int i = 0; i < 2; i++) for (int c = 0; c < 3; c++) st[i][c] = 0;
        @(negedge GCLK);
        @(negedge GCLK);
        RST = 1'b0;
        nz = 0;
        for (int j = 0; j < 15; j++) begin
            @(negedge GCLK);
            if (led != 6'd0) nz++;
        end
        check("post_rst_quiet", nz, 0);
        measure(-1, mode);
        check("post_rst_load_cyc", load_cyc, 15);
        expect_wheel("post_rst_l0", 0, ((load_cyc - 1) / 4) % 48);
        expect_led("post_rst_l1", 1, 0, 0, 0);
        check("post_rst_err3", int'(wr_err3), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
